// File: rtl/controle_rodadas.sv
// Round controller for the Simon-style music game: plays a growing
// prefix of the song, then checks the player's presses note by note.
module controle_rodadas #(
    parameter int N_BOTOES  = 4,
    parameter int ADDR_W    = 4,
    parameter int MAX_ERROS = 3,
    parameter int T_NOTA    = 1000,
    parameter int T_JOGADA  = 5000,
    localparam int ERR_W = (MAX_ERROS < 1) ? 1 : $clog2(MAX_ERROS + 1)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                jogar,
    input  logic                treinamento,
    input  logic [ADDR_W-1:0]   ultima_rodada,
    input  logic [N_BOTOES-1:0] nota_mem,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [ADDR_W-1:0]   endereco,
    output logic [ADDR_W-1:0]   rodada,
    output logic [ERR_W-1:0]    erros,
    output logic [N_BOTOES-1:0] nota_tocar,
    output logic                tocando,
    output logic                espera,
    output logic                acertou,
    output logic                perdeu,
    output logic                pronto,
    output logic [3:0]          db_estado
);

    localparam logic [3:0] INICIAL       = 4'h0;
    localparam logic [3:0] PREPARA       = 4'h1;
    localparam logic [3:0] TOCA_NOTA     = 4'h2;
    localparam logic [3:0] ESPERA_JOGADA = 4'h3;
    localparam logic [3:0] REGISTRA      = 4'h4;
    localparam logic [3:0] ESPERA_SOLTAR = 4'h5;
    localparam logic [3:0] COMPARACAO    = 4'h6;
    localparam logic [3:0] ERROU         = 4'h7;
    localparam logic [3:0] PROX_RODADA   = 4'h8;
    localparam logic [3:0] FIM_ACERTOU   = 4'h9;
    localparam logic [3:0] FIM_PERDEU    = 4'hA;
    localparam logic [3:0] MODO_TREINO   = 4'hB;

    localparam int T_MAX = (T_NOTA > T_JOGADA) ? T_NOTA : T_JOGADA;
    localparam int TMR_W = $clog2(T_MAX + 1);

    localparam logic [TMR_W-1:0] FIM_NOTA   = TMR_W'(T_NOTA - 1);
    localparam logic [TMR_W-1:0] FIM_JOGADA = TMR_W'(T_JOGADA - 1);
    localparam logic [ERR_W:0]   ERR_LIM    = (ERR_W + 1)'(MAX_ERROS);

    logic [3:0]          st_q,  st_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic [ADDR_W-1:0]   rod_q, rod_d;
    logic [ADDR_W-1:0]   lim_q, lim_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [N_BOTOES-1:0] reg_q, reg_d;

    logic [ERR_W:0]   err_inc;
    logic [ERR_W-1:0] err_sat;
    logic             press;

    // Unsaturated increment decides the loss; saturated one is stored.
    assign err_inc = {1'b0, err_q} + (ERR_W + 1)'(1);
    assign err_sat = (&err_q) ? err_q : err_q + ERR_W'(1);
    assign press   = (botoes != '0);

    always_comb begin
        st_d  = st_q;
        end_d = end_q;
        rod_d = rod_q;
        lim_d = lim_q;
        err_d = err_q;
        tmr_d = tmr_q;
        reg_d = reg_q;
        case (st_q)
            INICIAL: begin
                if (jogar) begin
                    st_d = treinamento ? MODO_TREINO : PREPARA;
                end
            end
            PREPARA: begin
                lim_d = ultima_rodada;
                rod_d = '0;
                end_d = '0;
                err_d = '0;
                tmr_d = '0;
                st_d  = TOCA_NOTA;
            end
            TOCA_NOTA: begin
                if (tmr_q == FIM_NOTA) begin
                    tmr_d = '0;
                    if (end_q == rod_q) begin
                        end_d = '0;
                        st_d  = ESPERA_JOGADA;
                    end else begin
                        end_d = end_q + ADDR_W'(1);
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ESPERA_JOGADA: begin
                if (press) begin
                    reg_d = botoes;
                    st_d  = REGISTRA;
                end else if (tmr_q == FIM_JOGADA) begin
                    st_d = ERROU;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            REGISTRA: st_d = ESPERA_SOLTAR;
            ESPERA_SOLTAR: begin
                if (!press) begin
                    st_d = COMPARACAO;
                end
            end
            COMPARACAO: begin
                tmr_d = '0;
                if (reg_q != nota_mem) begin
                    st_d = ERROU;
                end else if (end_q != rod_q) begin
                    end_d = end_q + ADDR_W'(1);
                    st_d  = ESPERA_JOGADA;
                end else begin
                    st_d = (rod_q == lim_q) ? FIM_ACERTOU : PROX_RODADA;
                end
            end
            ERROU: begin
                err_d = err_sat;
                if (MAX_ERROS != 0 && err_inc == ERR_LIM) begin
                    st_d = FIM_PERDEU;
                end else begin
                    end_d = '0;
                    tmr_d = '0;
                    st_d  = TOCA_NOTA;
                end
            end
            PROX_RODADA: begin
                rod_d = rod_q + ADDR_W'(1);
                end_d = '0;
                tmr_d = '0;
                st_d  = TOCA_NOTA;
            end
            FIM_ACERTOU, FIM_PERDEU: begin
                if (jogar) begin
                    st_d = PREPARA;
                end
            end
            MODO_TREINO: begin
                if (!treinamento) begin
                    st_d = INICIAL;
                end
            end
            default: st_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_q  <= INICIAL;
            end_q <= '0;
            rod_q <= '0;
            lim_q <= '0;
            err_q <= '0;
            tmr_q <= '0;
            reg_q <= '0;
        end else begin
            st_q  <= st_d;
            end_q <= end_d;
            rod_q <= rod_d;
            lim_q <= lim_d;
            err_q <= err_d;
            tmr_q <= tmr_d;
            reg_q <= reg_d;
        end
    end

    always_comb begin
        nota_tocar = '0;
        tocando    = 1'b0;
        if (st_q == TOCA_NOTA) begin
            nota_tocar = nota_mem;
            tocando    = 1'b1;
        end else if (st_q == MODO_TREINO) begin
            nota_tocar = botoes;
            tocando    = press;
        end
    end

    assign endereco  = end_q;
    assign rodada    = rod_q;
    assign erros     = err_q;
    assign espera    = (st_q == ESPERA_JOGADA);
    assign acertou   = (st_q == FIM_ACERTOU);
    assign perdeu    = (st_q == FIM_PERDEU);
    assign pronto    = acertou | perdeu;
    assign db_estado = st_q;

endmodule

// File: tb/tb_controle_rodadas.sv
// Random game play on two controllers (life limit 3 and unlimited),
// compared every cycle against a phase/elapsed-time game model.
module tb_controle_rodadas;

    localparam int TN = 3;
    localparam int TJ = 6;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       jogar = 1'b0;
    logic       treinamento = 1'b0;
    logic [3:0] ultima_rodada = 4'd0;
    logic [3:0] botoes = 4'd0;
    logic [3:0] song [16];

    logic [3:0] end_a, rod_a, nota_a, db_a, mem_a;
    logic [1:0] err_a;
    logic       toc_a, esp_a, ace_a, per_a, pro_a;
    logic [3:0] end_b, rod_b, nota_b, db_b, mem_b;
    logic [0:0] err_b;
    logic       toc_b, esp_b, ace_b, per_b, pro_b;

    assign mem_a = song[end_a];
    assign mem_b = song[end_b];

    controle_rodadas #(.N_BOTOES(4), .ADDR_W(4), .MAX_ERROS(3),
                       .T_NOTA(TN), .T_JOGADA(TJ)) dut_a (
        .clock(clock), .reset_n(reset_n), .jogar(jogar),
        .treinamento(treinamento), .ultima_rodada(ultima_rodada),
        .nota_mem(mem_a), .botoes(botoes), .endereco(end_a),
        .rodada(rod_a), .erros(err_a), .nota_tocar(nota_a),
        .tocando(toc_a), .espera(esp_a), .acertou(ace_a),
        .perdeu(per_a), .pronto(pro_a), .db_estado(db_a)
    );

    controle_rodadas #(.N_BOTOES(4), .ADDR_W(4), .MAX_ERROS(0),
                       .T_NOTA(TN), .T_JOGADA(TJ)) dut_b (
        .clock(clock), .reset_n(reset_n), .jogar(jogar),
        .treinamento(treinamento), .ultima_rodada(ultima_rodada),
        .nota_mem(mem_b), .botoes(botoes), .endereco(end_b),
        .rodada(rod_b), .erros(err_b), .nota_tocar(nota_b),
        .tocando(toc_b), .espera(esp_b), .acertou(ace_b),
        .perdeu(per_b), .pronto(pro_b), .db_estado(db_b)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        int ph;
        int el;
        int addr;
        int rnd;
        int lim;
        int err;
        logic [3:0] cap;
    } mdl_t;

    mdl_t ma, mb;
    int   total = 0;
    int   bad = 0;
    bit   lazy = 0;
    logic [3:0] ult_dir = 4'd0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t m_reset();
        mdl_t m;
        m = '0;
        return m;
    endfunction

    function automatic mdl_t m_step(input mdl_t m, input int maxe,
                                    input logic jg, input logic tr,
                                    input logic [3:0] ult,
                                    input logic [3:0] bt);
        mdl_t n;
        int   sat;
        n = m;
        sat = (maxe == 0) ? 1 : maxe;
        case (m.ph)
            0: if (jg) n.ph = tr ? 11 : 1;
            1: begin
                n.lim = int'(ult);
                n.rnd = 0; n.addr = 0; n.err = 0; n.el = 0;
                n.ph = 2;
            end
            2: begin
                if (m.el == (m.rnd + 1) * TN - 1) begin
                    n.el = 0; n.addr = 0; n.ph = 3;
                end else begin
                    n.el = m.el + 1;
                    n.addr = n.el / TN;
                end
            end
            3: begin
                if (bt != 4'd0) begin
                    n.cap = bt; n.ph = 4;
                end else if (m.el == TJ - 1) begin
                    n.ph = 7;
                end else begin
                    n.el = m.el + 1;
                end
            end
            4: n.ph = 5;
            5: if (bt == 4'd0) n.ph = 6;
            6: begin
                n.el = 0;
                if (m.cap != song[m.addr]) n.ph = 7;
                else if (m.addr != m.rnd) begin
                    n.addr = m.addr + 1; n.ph = 3;
                end else n.ph = (m.rnd == m.lim) ? 9 : 8;
            end
            7: begin
                n.err = (m.err + 1 > sat) ? sat : m.err + 1;
                if (maxe != 0 && m.err + 1 == maxe) n.ph = 10;
                else begin
                    n.addr = 0; n.el = 0; n.ph = 2;
                end
            end
            8: begin
                n.rnd = m.rnd + 1; n.addr = 0; n.el = 0; n.ph = 2;
            end
            9, 10: if (jg) n.ph = 1;
            11: if (!tr) n.ph = 0;
            default: n.ph = 0;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] m_out(input mdl_t m,
                                          input logic [3:0] bt);
        logic [3:0] nota;
        logic       toc;
        nota = 4'd0;
        toc = 1'b0;
        if (m.ph == 2) begin
            nota = song[m.addr];
            toc = 1'b1;
        end else if (m.ph == 11) begin
            nota = bt;
            toc = (bt != 4'd0);
        end
        return {9'd0, 4'(m.ph), 4'(m.addr), 4'(m.rnd), 2'(m.err), nota,
                toc, m.ph == 3, m.ph == 9, m.ph == 10,
                (m.ph == 9) || (m.ph == 10)};
    endfunction

    function automatic logic [31:0] out_a();
        return {9'd0, db_a, end_a, rod_a, err_a, nota_a,
                toc_a, esp_a, ace_a, per_a, pro_a};
    endfunction

    function automatic logic [31:0] out_b();
        return {9'd0, db_b, end_b, rod_b, 1'b0, err_b, nota_b,
                toc_b, esp_b, ace_b, per_b, pro_b};
    endfunction

    task automatic new_song();
        for (int i = 0; i < 16; i++) song[i] = 4'b0001 << ($urandom % 4);
    endtask

    // 0 random, 1 idle, 2 press on timeout cycle, 3 start,
    // 4 perfect player, 5 training on, 6 training off
    task automatic pick_inputs(input int mode);
        int r;
        case (mode)
            0: begin
                if (ma.ph == 1) lazy = ($urandom % 4 == 0);
                if (ma.ph == 0 || ma.ph == 9 || ma.ph == 10)
                    jogar = ($urandom % 4 == 0);
                else
                    jogar = ($urandom % 50 == 0);
                if (ma.ph == 11) treinamento = ($urandom % 8 != 0);
                else treinamento = ($urandom % 10 == 0);
                ultima_rodada = 4'($urandom % 4);
                r = $urandom % 10;
                case (ma.ph)
                    3: begin
                        if (lazy) botoes = 4'd0;
                        else if (r < 7) botoes = song[ma.addr];
                        else if (r == 7) botoes = 4'b0001 << ($urandom % 4);
                        else if (r == 8) botoes = 4'($urandom);
                        else botoes = 4'd0;
                    end
                    4, 5: if (r < 4) botoes = 4'd0;
                    11: botoes = 4'($urandom);
                    default: botoes = (r < 3) ? 4'($urandom) : 4'd0;
                endcase
            end
            2: begin
                jogar = 0; treinamento = 0;
                botoes = (ma.ph == 3 && ma.el == TJ - 1) ? song[ma.addr] : 4'd0;
            end
            3: begin
                jogar = 1; treinamento = 0; botoes = 0;
                ultima_rodada = ult_dir;
            end
            4: begin
                jogar = 0; treinamento = 0;
                botoes = (ma.ph == 3) ? song[ma.addr] : 4'd0;
            end
            5: begin
                jogar = 1; treinamento = 1; botoes = 4'b0100;
            end
            default: begin
                jogar = 0; treinamento = 0; botoes = 0;
            end
        endcase
    endtask

    task automatic one_cycle(input int mode);
        @(negedge clock);
        pick_inputs(mode);
        #1;
        chk("outs_A", out_a(), m_out(ma, botoes));
        chk("outs_B", out_b(), m_out(mb, botoes));
        @(posedge clock);
        ma = m_step(ma, 3, jogar, treinamento, ultima_rodada, botoes);
        mb = m_step(mb, 0, jogar, treinamento, ultima_rodada, botoes);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        jogar = 0; treinamento = 0; botoes = 0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_A", out_a(), 32'd0);
        chk("rst_B", out_b(), 32'd0);
        ma = m_reset();
        mb = m_reset();
        new_song();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        new_song();
        ma = m_reset();
        mb = m_reset();
        #1;
        chk("por_A", out_a(), 32'd0);
        chk("por_B", out_b(), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // start, then abort in the middle of playback
        ult_dir = 4'd2;
        one_cycle(3);
        chk("start_prepara", {28'd0, db_a}, 32'd1);
        one_cycle(1);
        chk("start_toca", {28'd0, db_a}, 32'd2);
        one_cycle(1);
        do_reset();

        // perfect game over three rounds
        song[0] = 4'b0001; song[1] = 4'b0010; song[2] = 4'b0100;
        ult_dir = 4'd2;
        one_cycle(3);
        for (int i = 0; i < 200 && ma.ph != 9 && bad < 40; i++) one_cycle(4);
        chk("win_state", {28'd0, db_a}, 32'd9);
        chk("win_flags", {29'd0, ace_a, pro_a, per_a}, 32'b110);
        chk("win_rodada", {28'd0, rod_a}, 32'd2);
        chk("win_erros", {30'd0, err_a}, 32'd0);
        one_cycle(1);
        do_reset();

        // no presses: three timeouts lose A, B keeps going
        ult_dir = 4'd1;
        one_cycle(3);
        for (int i = 0; i < 300 && ma.ph != 10 && bad < 40; i++) one_cycle(1);
        chk("lose_state", {28'd0, db_a}, 32'hA);
        chk("lose_erros", {30'd0, err_a}, 32'd3);
        for (int i = 0; i < 220 && bad < 40; i++) one_cycle(1);
        chk("unlim_not_lost", {31'd0, per_b}, 32'd0);
        chk("unlim_erros", {31'd0, err_b}, 32'd1);
        do_reset();

        // press exactly on the timeout cycle
        ult_dir = 4'd1;
        one_cycle(3);
        for (int i = 0; i < 80 && bad < 40; i++) one_cycle(2);
        do_reset();

        // training mode
        one_cycle(5);
        chk("treino_state", {28'd0, db_a}, 32'hB);
        chk("treino_nota", {27'd0, nota_a, toc_a}, {27'd0, 4'b0100, 1'b1});
        one_cycle(5);
        one_cycle(6);
        chk("treino_sai", {28'd0, db_a}, 32'd0);

        for (int i = 0; i < 8000 && bad < 40; i++) begin
            if (i % 1700 == 1699) do_reset();
            else one_cycle(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
